// File: rtl/game_pkg.sv
// Shared playfield/sprite defaults and the actor controller state encoding.
package game_pkg;

  localparam int GAME_WIDTH_DEF    = 640;
  localparam int GAME_HEIGHT_DEF   = 480;
  localparam int GRID_WIDTH_DEF    = 32;
  localparam int GRID_HEIGHT_DEF   = 32;
  localparam int PLAYER_WIDTH_DEF  = 32;
  localparam int PLAYER_HEIGHT_DEF = 32;

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_HIT       = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/grid_actor_ctrl_tick_gen.sv
// Free-running move-opportunity counter; o_Tick is a one-cycle enable, not a clock.
module tick_gen #(
  parameter int MOVE_TICKS = 2_500_000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  output logic o_Tick
);

  localparam int            CW   = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(MOVE_TICKS - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  assign o_Tick = (count_q == LAST);

endmodule

// File: rtl/grid_actor_ctrl.sv
// Grid-stepping actor: moves on ticks, levels up at the top row, loses lives on collisions.
module grid_actor_ctrl
  import game_pkg::*;
#(
  parameter int GAME_WIDTH    = GAME_WIDTH_DEF,
  parameter int GAME_HEIGHT   = GAME_HEIGHT_DEF,
  parameter int GRID_WIDTH    = GRID_WIDTH_DEF,
  parameter int GRID_HEIGHT   = GRID_HEIGHT_DEF,
  parameter int PLAYER_WIDTH  = PLAYER_WIDTH_DEF,
  parameter int PLAYER_HEIGHT = PLAYER_HEIGHT_DEF,
  parameter int MOVE_TICKS    = 2_500_000,
  parameter int RESPAWN_TICKS = 4,
  parameter int START_LIVES   = 3,
  parameter int MAX_LEVEL     = 9
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Up,
  input  logic       i_Dn,
  input  logic       i_Lt,
  input  logic       i_Rt,
  input  logic       i_Collision,
  input  logic       i_Start,
  output logic [9:0] o_X,
  output logic [9:0] o_Y,
  output logic [3:0] o_Level,
  output logic [2:0] o_Lives,
  output logic       o_Level_Up,
  output logic       o_Game_Over
);

  localparam int START_X = (GAME_WIDTH / 2) / GRID_WIDTH * GRID_WIDTH;
  localparam int START_Y = (GAME_HEIGHT - PLAYER_HEIGHT) / GRID_HEIGHT * GRID_HEIGHT;

  localparam logic [9:0]  START_X_V = 10'(START_X);
  localparam logic [9:0]  START_Y_V = 10'(START_Y);
  localparam logic [9:0]  GW_V      = 10'(GRID_WIDTH);
  localparam logic [9:0]  GH_V      = 10'(GRID_HEIGHT);
  localparam logic [10:0] X_LIM     = 11'(GAME_WIDTH - PLAYER_WIDTH);
  localparam logic [10:0] Y_LIM     = 11'(GAME_HEIGHT - PLAYER_HEIGHT);
  localparam logic [2:0]  LIVES_V   = 3'(START_LIVES);
  localparam logic [3:0]  MAXLVL_V  = 4'(MAX_LEVEL);

  localparam int            RW        = $clog2(RESPAWN_TICKS + 1);
  localparam logic [RW-1:0] RESP_LAST = RW'(RESPAWN_TICKS - 1);

  state_t        state_q;
  logic [9:0]    x_q, y_q;
  logic [3:0]    level_q;
  logic [2:0]    lives_q;
  logic          level_up_q;
  logic          game_over_q;
  logic [RW-1:0] respawn_q;
  logic [9:0]    x_d, y_d;
  logic          tick;

  tick_gen #(.MOVE_TICKS(MOVE_TICKS)) u_tick_gen (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .o_Tick (tick)
  );

  // Candidate position for a move tick; 11-bit sums keep the edge tests free of wrap.
  always_comb begin
    y_d = y_q;
    x_d = x_q;
    if (i_Up) begin
      if (y_q >= GH_V) y_d = y_q - GH_V;
    end else if (i_Dn && (({1'b0, y_q} + {1'b0, GH_V}) <= Y_LIM)) begin
      y_d = y_q + GH_V;
    end
    if (i_Lt) begin
      if (x_q >= GW_V) x_d = x_q - GW_V;
    end else if (i_Rt && (({1'b0, x_q} + {1'b0, GW_V}) <= X_LIM)) begin
      x_d = x_q + GW_V;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q     <= ST_PLAY;
      x_q         <= START_X_V;
      y_q         <= START_Y_V;
      level_q     <= 4'd1;
      lives_q     <= LIVES_V;
      level_up_q  <= 1'b0;
      game_over_q <= 1'b0;
      respawn_q   <= '0;
    end else begin
      level_up_q <= 1'b0;
      case (state_q)
        ST_PLAY: begin
          // Reaching the top row outranks a collision, which outranks a move.
          if (y_q == 10'd0) begin
            x_q        <= START_X_V;
            y_q        <= START_Y_V;
            level_q    <= sat_inc4(level_q, MAXLVL_V);
            level_up_q <= 1'b1;
          end else if (i_Collision) begin
            x_q <= START_X_V;
            y_q <= START_Y_V;
            if (lives_q > 3'd1) begin
              lives_q   <= lives_q - 3'd1;
              respawn_q <= '0;
              state_q   <= ST_HIT;
            end else begin
              lives_q     <= 3'd0;
              game_over_q <= 1'b1;
              state_q     <= ST_GAME_OVER;
            end
          end else if (tick) begin
            x_q <= x_d;
            y_q <= y_d;
          end
        end
        ST_HIT: begin
          if (tick) begin
            if (respawn_q == RESP_LAST) begin
              respawn_q <= '0;
              state_q   <= ST_PLAY;
            end else begin
              respawn_q <= respawn_q + RW'(1);
            end
          end
        end
        ST_GAME_OVER: begin
          if (i_Start) begin
            x_q         <= START_X_V;
            y_q         <= START_Y_V;
            level_q     <= 4'd1;
            lives_q     <= LIVES_V;
            game_over_q <= 1'b0;
            state_q     <= ST_PLAY;
          end
        end
        default: state_q <= ST_PLAY;
      endcase
    end
  end

  assign o_X         = x_q;
  assign o_Y         = y_q;
  assign o_Level     = level_q;
  assign o_Lives     = lives_q;
  assign o_Level_Up  = level_up_q;
  assign o_Game_Over = game_over_q;

endmodule
